axi_ad9364_dac_feed: RTL

- Transmit-side source stage directly upstream of the AD9364 digital interface.
- Accepts I/Q samples on a valid/ready stream and buffers them in a small FIFO.
- Drives the interface's dac_valid/dac_data_* inputs at the cadence the interface consumes: one slot every 2 clk in 1R1T mode, every 4 clk in 2R2T mode.
- Also carries a built-in alternating-pattern generator for bring-up, plus underflow monitoring.

---
 rtl/axi_ad9364_pkg.sv | 17 +
 rtl/axi_ad9364_sync_fifo.sv | 45 ++++
 rtl/axi_ad9364_dac_feed.sv | 88 ++++++++
 3 files changed

// File: rtl/axi_ad9364_pkg.sv
// axi_ad9364_pkg: shared sample-set type, slot periods and default pattern words
package axi_ad9364_pkg;
  localparam int LANE_W = 12;
  localparam int SAMPLE_W = 4 * LANE_W;
  localparam int P_R1 = 2;
  localparam int P_R2 = 4;
  localparam logic [LANE_W-1:0] PAT_I_A_DEF = 12'o2064;
  localparam logic [LANE_W-1:0] PAT_Q_A_DEF = 12'o1753;
  localparam logic [LANE_W-1:0] PAT_I_B_DEF = 12'o4402;
  localparam logic [LANE_W-1:0] PAT_Q_B_DEF = 12'o1337;
  typedef struct packed {
    logic [LANE_W-1:0] i1;
    logic [LANE_W-1:0] q1;
    logic [LANE_W-1:0] i2;
    logic [LANE_W-1:0] q2;
  } sample_t;
endpackage

// File: rtl/axi_ad9364_sync_fifo.sv
// axi_ad9364_sync_fifo: synchronous FIFO with flush, no write-to-read bypass
module axi_ad9364_sync_fifo
  import axi_ad9364_pkg::*;
#(
  parameter int W = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wp, rp;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign dout = mem[rd_ptr];
  assign wp = push && !full && !flush;
  assign rp = pop && !empty && !flush;
  // pointers and occupancy; flush drops any same-edge push
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (wp) wr_ptr <= wr_ptr + 1'b1;
      if (rp) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(wp) - LW'(rp);
    end
  end
  // storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (wp) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/axi_ad9364_dac_feed.sv
// axi_ad9364_dac_feed: paces buffered or pattern I/Q sets into the AD9364 DAC slots
module axi_ad9364_dac_feed
  import axi_ad9364_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter logic [11:0] PAT_I_A = PAT_I_A_DEF,
  parameter logic [11:0] PAT_Q_A = PAT_Q_A_DEF,
  parameter logic [11:0] PAT_I_B = PAT_I_B_DEF,
  parameter logic [11:0] PAT_Q_B = PAT_Q_B_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          dac_enable,
  input  logic                          r1_mode,
  input  logic                          pattern_en,
  input  logic                          fifo_flush,
  input  logic                          underflow_clr,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [11:0]                   s_data_i1,
  input  logic [11:0]                   s_data_q1,
  input  logic [11:0]                   s_data_i2,
  input  logic [11:0]                   s_data_q2,
  output logic                          dac_valid,
  output logic [11:0]                   dac_data_i1,
  output logic [11:0]                   dac_data_q1,
  output logic [11:0]                   dac_data_i2,
  output logic [11:0]                   dac_data_q2,
  output logic                          dac_r1_mode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic [15:0]                   underflow_count
);
  sample_t din, dout, pat, dac_d;
  logic [1:0] cnt;
  logic phase, full, empty, slot, pop, uf_ev;
  assign din = {s_data_i1, s_data_q1, s_data_i2, s_data_q2};
  assign {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2} = dac_d;
  assign s_ready = rstn && !full && !pattern_en;
  assign slot = dac_enable && cnt == 2'd0;
  assign pop = slot && !pattern_en && !empty && !fifo_flush;
  assign uf_ev = slot && !pattern_en && (empty || fifo_flush);
  assign pat = phase ? {PAT_I_B, PAT_Q_B, PAT_I_B, PAT_Q_B} : {PAT_I_A, PAT_Q_A, PAT_I_A, PAT_Q_A};

  axi_ad9364_sync_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .flush(fifo_flush),
    .push(s_valid && s_ready),
    .pop(pop),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );

  // slot counter, mode latch, pattern phase and the registered DAC strobe/data
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= 2'd0;
      dac_valid <= 1'b0;
      dac_r1_mode <= 1'b0;
      phase <= 1'b0;
      dac_d <= '0;
    end else begin
      cnt <= !dac_enable ? 2'd0 : (cnt == 2'(dac_r1_mode ? P_R1 - 1 : P_R2 - 1)) ? 2'd0 : cnt + 2'd1;
      dac_valid <= slot;
      if (slot) dac_r1_mode <= r1_mode;
      if (slot && pattern_en) phase <= !phase;
      dac_d <= !dac_enable ? '0 : !slot ? dac_d : pattern_en ? pat : pop ? dout : '0;
    end
  end

  // sticky underflow flag and saturating count; a same-edge underflow beats clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      underflow <= 1'b0;
      underflow_count <= 16'd0;
    end else if (uf_ev) begin
      underflow <= 1'b1;
      underflow_count <= underflow_clr ? 16'd1 : (&underflow_count) ? underflow_count : underflow_count + 16'd1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
      underflow_count <= 16'd0;
    end
  end
endmodule
